// File: rtl/regfile_scoreboard_if.sv
// Issue/read/write bundle between decode-issue, writeback and the
// scoreboarded register file.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic                 flush;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;
  logic                 issue_ready;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_dirty;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;

  modport master (
    output flush, issue_en, issue_addr,
    output rd_en, rd_addr,
    output wr_en, wr_addr, wr_data,
    input  issue_ready, rd_data, rd_dirty
  );

  modport slave (
    input  flush, issue_en, issue_addr,
    input  rd_en, rd_addr,
    input  wr_en, wr_addr, wr_data,
    output issue_ready, rd_data, rd_dirty
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a saturating pending-write
// counter per register and optional write-to-read bypass.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int PW     = 2,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic reset_n,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int KW = $clog2(NWR + 1);
  localparam logic [PW-1:0] PMAX = '1;

  logic [XLEN-1:0] r_mem  [NREG];
  logic [PW-1:0]   r_pend [NREG];

  logic            w_hit [NREG];
  logic [KW-1:0]   w_k   [NREG];
  logic [XLEN-1:0] w_wd  [NREG];
  logic            w_inc [NREG];
  logic [PW-1:0]   w_pn  [NREG];
  logic            w_acc;

  assign bus.issue_ready = (bus.issue_addr == '0) |
                           (r_pend[bus.issue_addr] != PMAX);
  assign w_acc = bus.issue_en & bus.issue_ready;

  // Later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_hit[r] = 1'b0;
      w_k[r]   = '0;
      w_wd[r]  = '0;
      for (int p = 0; p < NWR; p++) begin
        if (r != 0 && bus.wr_en[p] &&
            bus.wr_addr[p*AW +: AW] == AW'(r)) begin
          w_hit[r] = 1'b1;
          w_k[r]   = w_k[r] + KW'(1);
          w_wd[r]  = bus.wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      int t;
      w_inc[r] = w_acc && (r != 0) &&
                 (bus.issue_addr == AW'(r));
      t = int'(r_pend[r]) + int'(w_inc[r]) - int'(w_k[r]);
      if (t < 0) t = 0;
      w_pn[r] = bus.flush ? '0 : PW'(t);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_mem[r]  <= '0;
        r_pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_hit[r]) r_mem[r] <= w_wd[r];
        r_pend[r] <= w_pn[r];
      end
    end
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_dirty = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic          on;
      logic          byp;
      a   = bus.rd_addr[i*AW +: AW];
      on  = bus.rd_en[i] && (a != '0);
      byp = (BYPASS != 0) && w_hit[a];
      unique case (1'b1)
        !on: begin
          bus.rd_data[i*XLEN +: XLEN] = '0;
          bus.rd_dirty[i] = 1'b0;
        end
        on && byp: begin
          bus.rd_data[i*XLEN +: XLEN] = w_wd[a];
          bus.rd_dirty[i] = int'(r_pend[a]) > int'(w_k[a]);
        end
        on && !byp: begin
          bus.rd_data[i*XLEN +: XLEN] = r_mem[a];
          bus.rd_dirty[i] = r_pend[a] != '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: bypass (A) and non-bypass (B) instances share one
// stimulus stream; expectations go through a queue.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if ia();
  regfile_scoreboard_if ib();

  assign ib.flush      = ia.flush;
  assign ib.issue_en   = ia.issue_en;
  assign ib.issue_addr = ia.issue_addr;
  assign ib.rd_en      = ia.rd_en;
  assign ib.rd_addr    = ia.rd_addr;
  assign ib.wr_en      = ia.wr_en;
  assign ib.wr_addr    = ia.wr_addr;
  assign ib.wr_data    = ia.wr_data;

  regfile_scoreboard #(.BYPASS(1)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );
  regfile_scoreboard #(.BYPASS(0)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL underflow obs=%h exp=none", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic look(input string tag, input int p,
                      input logic [31:0] da, input logic xa,
                      input logic [31:0] db, input logic xb);
    push({tag, ".Ad"}, da);
    push({tag, ".Ax"}, 32'(xa));
    push({tag, ".Bd"}, db);
    push({tag, ".Bx"}, 32'(xb));
    #1;
    chk(ia.rd_data[p*32 +: 32]);
    chk(32'(ia.rd_dirty[p]));
    chk(ib.rd_data[p*32 +: 32]);
    chk(32'(ib.rd_dirty[p]));
  endtask

  task automatic rdy(input string tag, input logic e);
    push({tag, ".Ar"}, 32'(e));
    push({tag, ".Br"}, 32'(e));
    #1;
    chk(32'(ia.issue_ready));
    chk(32'(ib.issue_ready));
  endtask

  task automatic idle();
    ia.flush      = 1'b0;
    ia.issue_en   = 1'b0;
    ia.issue_addr = '0;
    ia.rd_en      = '0;
    ia.rd_addr    = '0;
    ia.wr_en      = '0;
    ia.wr_addr    = '0;
    ia.wr_data    = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    ia.rd_en[p] = 1'b1;
    ia.rd_addr[p*5 +: 5] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a,
                    input logic [31:0] d);
    ia.wr_en[p] = 1'b1;
    ia.wr_addr[p*5 +: 5] = a;
    ia.wr_data[p*32 +: 32] = d;
  endtask

  task automatic iss(input logic [4:0] a);
    ia.issue_en   = 1'b1;
    ia.issue_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rd(0, 5); rd(1, 5);
    #2;
    rdy("rst_rdy", 1'b1);
    look("rst_p0", 0, 0, 0, 0, 0);
    look("rst_p1", 1, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    idle(); rd(0, 5); rd(1, 5);
    look("x5_p0", 0, 0, 0, 0, 0);
    rdy("x5_rdy", 1'b1);
    idle(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
    look("x5_wr", 0, 32'hDEADBEEF, 0, 0, 0);
    tick();
    idle(); rd(1, 5);
    look("x5_after", 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);

    for (int n = 0; n < 3; n++) begin
      idle(); iss(7);
      rdy("x7_iss", 1'b1);
      tick();
    end
    idle(); rd(1, 7); ia.issue_addr = 7;
    look("x7_p3", 1, 0, 1, 0, 1);
    rdy("x7_full", 1'b0);
    iss(7);
    rdy("x7_4th", 1'b0);
    tick();
    idle(); wr(0, 7, 32'h1); rd(1, 7); ia.issue_addr = 7;
    look("x7_w1", 1, 32'h1, 1, 0, 1);
    rdy("x7_w1_rdy", 1'b0);
    tick();
    idle(); wr(0, 7, 32'h2); rd(1, 7); ia.issue_addr = 7;
    look("x7_w2", 1, 32'h2, 1, 32'h1, 1);
    rdy("x7_w2_rdy", 1'b1);
    tick();
    idle(); wr(0, 7, 32'h3); rd(1, 7);
    look("x7_w3", 1, 32'h3, 0, 32'h2, 1);
    tick();
    idle(); rd(0, 7);
    look("x7_end", 0, 32'h3, 0, 32'h3, 0);

    idle(); iss(9);
    tick();
    idle(); wr(0, 9, 32'hA5A5A5A5); rd(0, 9);
    look("x9_byp", 0, 32'hA5A5A5A5, 0, 0, 1);
    tick();
    idle(); rd(0, 9);
    look("x9_end", 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);

    idle(); iss(3);
    tick();
    tick();
    idle(); wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(1, 3);
    look("x3_dual", 1, 32'h22, 0, 0, 1);
    tick();
    idle(); rd(0, 3);
    look("x3_end", 0, 32'h22, 0, 32'h22, 0);

    idle(); iss(4);
    tick();
    idle(); iss(4); wr(0, 4, 32'h44); rd(0, 4);
    look("x4_iw", 0, 32'h44, 0, 0, 1);
    tick();
    idle(); rd(0, 4);
    look("x4_p1", 0, 32'h44, 1, 32'h44, 1);
    ia.flush = 1'b1; iss(4); wr(0, 4, 32'h77);
    look("x4_fl", 0, 32'h77, 0, 32'h44, 1);
    tick();
    idle(); rd(0, 4); ia.issue_addr = 4;
    look("x4_end", 0, 32'h77, 0, 32'h77, 0);
    rdy("x4_rdy", 1'b1);

    idle(); iss(0); wr(1, 0, 32'hFFFFFFFF); rd(0, 0); rd(1, 0);
    rdy("x0_rdy", 1'b1);
    look("x0_now", 0, 0, 0, 0, 0);
    tick();
    idle(); rd(1, 0);
    look("x0_next", 1, 0, 0, 0, 0);

    idle(); iss(7);
    tick();
    tick();
    idle(); rd(0, 7); rd(1, 5); ia.issue_addr = 7;
    look("x7_p2", 0, 32'h3, 1, 32'h3, 1);
    reset_n = 1'b0;
    look("mid_rst7", 0, 0, 0, 0, 0);
    look("mid_rst5", 1, 0, 0, 0, 0);
    rdy("mid_rdy", 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    idle(); rd(0, 7);
    look("post_rst", 0, 0, 0, 0, 0);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL leftover obs=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $fatal(1, "FAIL timeout obs=running exp=finished");
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port integer register file with a per-register pending-write scoreboard. It generalises the single-write, dual-read, one-bit-dirty register file. Width, depth and read/write port counts are parameters. Each register has a saturating pending counter, so several in-flight writers can target the same register, and write-to-read bypass is optional. It sits between decode/issue, which allocates destinations and reads operands, and the writeback stage(s).

## Interface
- XLEN, 32: data width.
- NREG, 32: register count (power of 2, ≥2); AW = clog2(NREG).
- NRD, 2: read ports.
- NWR, 2: write ports.
- PW, 2: pending-counter width; max outstanding per register = 2^PW−1.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  clear all pending counters.
- issue_en  in  1  allocate one pending write to issue_addr.
- issue_addr  in  AW  destination register being allocated.
- issue_ready  out  1  allocation accepted this cycle.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data.
- rd_dirty  out  NRD  register has outstanding writers.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.

## Operation
- Register 0 is hardwired to 0 and is never dirty. Issues to 0 are accepted and have no effect. Writes to 0 are ignored.
- Data write:
  - Each register updates when any write port targets it.
  - If several ports hit the same register in one cycle, the highest port index wins.
- Pending counter pend[r] (PW bits) next state, in priority order:
  - If flush: 0.
  - Otherwise: pend[r] + inc − k.
    - inc = 1 if issue_en & issue_ready & issue_addr==r & r≠0.
    - k = number of write ports hitting r this cycle.
  - The result clamps at 0. An unmatched write, or a write after flush, leaves the counter at 0.
- flush does not block same-cycle data writes. An issue in the flush cycle is discarded.
- issue_ready = (issue_addr==0) | (pend[issue_addr] != 2^PW−1). It is combinational and uses only the registered count; a same-cycle write does not free a slot. When issue_en is high and issue_ready is low, nothing changes; the issuer holds and retries.
- Read port i (combinational):
  - rd_en[i]=0: rd_data = 0, rd_dirty = 0.
  - BYPASS=0: rd_data = MEM[addr]; rd_dirty = (pend[addr] != 0).
  - BYPASS=1, at least one write port hitting addr (addr≠0):
    - rd_data = wr_data of the highest hitting port.
    - rd_dirty = (pend[addr] > k), with k counted as in the pending-counter rule.
    - A same-cycle issue is not visible to reads until the next cycle.
  - BYPASS=1, no write hitting addr: same as BYPASS=0.
  - Address 0 always returns data 0 and dirty 0.

## Timing
- Reset (asynchronous assert):
  - All MEM = 0, all pend = 0.
  - Outputs: rd_data = 0 and rd_dirty = 0 for all ports; issue_ready = 1.
- Reset release is synchronous to clk. Reset mid-operation discards all outstanding allocations.
- Write latency: data is visible at the MEM output the cycle after wr_en. With BYPASS=1 it is visible in the same cycle.
- The issue increment is visible on rd_dirty the cycle after acceptance.
- Read ports have no handshake. All read ports are independent and may alias each other or write addresses.
- There is no combinational path from rd_* to issue_ready, or from wr_* to issue_ready.

## Test plan
- Reset, then read x5 on both ports → data 0, dirty 0, issue_ready 1. Write x5=0xDEADBEEF with no issue → next cycle data 0xDEADBEEF, dirty 0, pend 0.
- Issue x7 three times (PW=2) → pend 3, rd_dirty 1, issue_ready 0 for x7. Fourth issue is ignored. Three writes 0x1, 0x2, 0x3 on successive cycles → dirty 1, 1, then 0; final data 0x3.
- BYPASS=1: pend[x9]=1; write x9=0xA5A5A5A5 on port 0 while reading x9 → same cycle rd_data 0xA5A5A5A5, rd_dirty 0. BYPASS=0: same stimulus → old data, dirty 1.
- Ports 0 and 1 both write x3 (0x11, 0x22) in one cycle with pend[x3]=2 → MEM[x3]=0x22, pend 0, bypass read returns 0x22.
- Issue x4 and write x4 in the same cycle with pend=1 → pend stays 1. Then flush together with issue x4 and write x4=0x77 → pend 0, data 0x77.
- Issue and write to x0, read x0 → data 0, dirty 0, issue_ready 1. Assert reset_n low mid-sequence with pend[x7]=2 → dirty and data cleared immediately.
